// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: loads program words into the instruction RAM,
// then fetches, decodes HALT, and hands instructions to the datapath one at a time.
module instr_fetch_ctrl #(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 16,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ack,
    output logic              iram_en,
    output logic              iram_read_en,
    output logic              iram_write_en,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [DATA_W-1:0] iram_wdata,
    input  logic [DATA_W-1:0] iram_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              exec_valid,
    input  logic              exec_done,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_exec_first;
    logic              w_is_halt;
    logic              w_resume;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_is_halt = (iram_rdata[DATA_W-1 -: 4] == HALT_OP);
    // A loader request always wins over start in the same cycle.
    assign w_resume  = start && !load_req;
    assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // State register and fetch datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_exec_first <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_exec_first <= (r_state == S_WAIT);
            if (r_state == S_WAIT) begin
                r_ir <= iram_rdata;
            end
            if (r_state == S_EXEC && exec_done) begin
                r_pc <= branch_take ? branch_target : w_pc_inc;
            end else if (r_state == S_HALT && w_resume) begin
                r_pc <= '0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_resume) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_WAIT;
            S_WAIT:  w_state_next = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC:  if (exec_done) w_state_next = S_FETCH;
            S_HALT:  if (w_resume) w_state_next = S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        load_ack      = 1'b0;
        iram_en       = 1'b0;
        iram_read_en  = 1'b0;
        iram_write_en = 1'b0;
        iram_addr     = '0;
        iram_wdata    = '0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (load_req) begin
                    load_ack      = 1'b1;
                    iram_en       = 1'b1;
                    iram_write_en = 1'b1;
                    iram_addr     = load_addr;
                    iram_wdata    = load_data;
                end
            end
            S_FETCH: begin
                iram_en      = 1'b1;
                iram_read_en = 1'b1;
                iram_addr    = r_pc;
            end
            default: ;
        endcase
    end

    assign exec_valid = (r_state == S_EXEC) && r_exec_first;
    assign halted     = (r_state == S_HALT);
    assign busy       = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_EXEC);
    assign pc         = r_pc;
    assign ir         = r_ir;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: cycle table for load/run/branch/wrap,
// plus hand sequences for reset-in-WAIT, start latency and reset priority.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_req;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        load_ack;
    logic        iram_en;
    logic        iram_read_en;
    logic        iram_write_en;
    logic [7:0]  iram_addr;
    logic [15:0] iram_wdata;
    logic [15:0] iram_rdata;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        exec_valid;
    logic        exec_done;
    logic        branch_take;
    logic [7:0]  branch_target;
    logic        halted;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .HALT_OP(4'hF)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_req      (load_req),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_ack      (load_ack),
        .iram_en       (iram_en),
        .iram_read_en  (iram_read_en),
        .iram_write_en (iram_write_en),
        .iram_addr     (iram_addr),
        .iram_wdata    (iram_wdata),
        .iram_rdata    (iram_rdata),
        .pc            (pc),
        .ir            (ir),
        .exec_valid    (exec_valid),
        .exec_done     (exec_done),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .halted        (halted),
        .busy          (busy)
    );

    // Instruction RAM with one-cycle registered read
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (iram_en && iram_write_en) mem[iram_addr] <= iram_wdata;
        if (iram_en && iram_read_en)  iram_rdata <= mem[iram_addr];
    end

    // Read and write strobes must never coincide
    always @(negedge clk) begin
        #1;
        if (iram_read_en && iram_write_en) begin
            $display("FAIL rd_wr_excl: got rd=1 wr=1, required not both");
            n_bad++;
        end
    end

    typedef struct packed {
        logic        st, lr;
        logic [7:0]  la;
        logic [15:0] ld;
        logic        dn, bt;
        logic [7:0]  bg;
        logic        ack, en, rd, wr;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        ev, hl, bs;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic st, input logic lr, input logic [7:0] la, input logic [15:0] ld,
        input logic dn, input logic bt, input logic [7:0] bg,
        input logic ack, input logic en, input logic rd, input logic wr,
        input logic [7:0] addr, input logic [15:0] wd, input logic [7:0] p,
        input logic [15:0] i, input logic ev, input logic hl, input logic bs);
        vec_t v;
        v = '{st, lr, la, ld, dn, bt, bg, ack, en, rd, wr, addr, wd, p, i, ev, hl, bs};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            $display("FAIL %s: got %h, required %h", name, act, req);
            n_bad++;
        end else begin
            $display("check %s = %h", name, act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [54:0] act;
        logic [54:0] req;
        int          n;

        // IDLE loads, including words at 0x40 and 0xFF for the branch/wrap tests
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'h0000,0,0,0));
        vq.push_back(mk(0,1,8'h40,16'h4444,0,0,8'h00, 1,1,0,1,8'h40,16'h4444,8'h00,16'h0000,0,0,0));
        vq.push_back(mk(0,1,8'hFF,16'h5555,0,0,8'h00, 1,1,0,1,8'hFF,16'h5555,8'h00,16'h0000,0,0,0));
        vq.push_back(mk(0,1,8'h00,16'h1005,0,0,8'h00, 1,1,0,1,8'h00,16'h1005,8'h00,16'h0000,0,0,0));
        vq.push_back(mk(0,1,8'h01,16'h2007,0,0,8'h00, 1,1,0,1,8'h01,16'h2007,8'h00,16'h0000,0,0,0));
        // start together with load: write wins, FETCH deferred
        vq.push_back(mk(1,1,8'h02,16'hF000,0,0,8'h00, 1,1,0,1,8'h02,16'hF000,8'h00,16'h0000,0,0,0));
        vq.push_back(mk(1,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'h0000,0,0,0));
        // Run 0x1005, 0x2007, then HALT at pc=2 (exec_done held high)
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,1,1,0,8'h00,16'h0000,8'h00,16'h0000,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'h0000,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'h1005,1,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,1,1,0,8'h01,16'h0000,8'h01,16'h1005,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h01,16'h1005,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h01,16'h2007,1,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,1,1,0,8'h02,16'h0000,8'h02,16'h2007,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h02,16'h2007,0,0,1));
        // HALT: loads served, exec_done ignored, then restart from 0
        vq.push_back(mk(0,1,8'h04,16'h3000,1,0,8'h00, 1,1,0,1,8'h04,16'h3000,8'h02,16'hF000,0,1,0));
        vq.push_back(mk(0,1,8'h05,16'hF000,0,0,8'h00, 1,1,0,1,8'h05,16'hF000,8'h02,16'hF000,0,1,0));
        vq.push_back(mk(1,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h02,16'hF000,0,1,0));
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,1,1,0,8'h00,16'h0000,8'h00,16'hF000,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'hF000,0,0,1));
        // EXEC held one extra cycle, then branch to 4
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'h1005,1,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,1,1,8'h04, 0,0,0,0,8'h00,16'h0000,8'h00,16'h1005,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,1,1,0,8'h04,16'h0000,8'h04,16'h1005,0,0,1));
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h04,16'h1005,0,0,1));
        // Word at 4 branches to 0x40; load_req held from here is ignored until HALT
        vq.push_back(mk(0,1,8'h09,16'hAAAA,1,1,8'h40, 0,0,0,0,8'h00,16'h0000,8'h04,16'h3000,1,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,1,0,8'h00, 0,1,1,0,8'h40,16'h0000,8'h40,16'h3000,0,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h40,16'h3000,0,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,1,1,8'hFF, 0,0,0,0,8'h00,16'h0000,8'h40,16'h4444,1,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,1,1,0,8'hFF,16'h0000,8'hFF,16'h4444,0,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'hFF,16'h4444,0,0,1));
        // pc wraps 0xFF -> 0x00
        vq.push_back(mk(0,1,8'h09,16'hAAAA,1,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'hFF,16'h5555,1,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,1,1,0,8'h00,16'h0000,8'h00,16'h5555,0,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h00,16'h5555,0,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,1,1,8'h05, 0,0,0,0,8'h00,16'h0000,8'h00,16'h1005,1,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,1,1,0,8'h05,16'h0000,8'h05,16'h1005,0,0,1));
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h05,16'h1005,0,0,1));
        // HALT at 5: held load finally acknowledged
        vq.push_back(mk(0,1,8'h09,16'hAAAA,0,0,8'h00, 1,1,0,1,8'h09,16'hAAAA,8'h05,16'hF000,0,1,0));
        vq.push_back(mk(0,0,8'h00,16'h0000,0,0,8'h00, 0,0,0,0,8'h00,16'h0000,8'h05,16'hF000,0,1,0));

        reset = 1'b1; start = 1'b0; load_req = 1'b0; load_addr = '0; load_data = '0;
        exec_done = 1'b0; branch_take = 1'b0; branch_target = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].st; load_req = vq[i].lr; load_addr = vq[i].la; load_data = vq[i].ld;
            exec_done = vq[i].dn; branch_take = vq[i].bt; branch_target = vq[i].bg;
            #1;
            act = {load_ack, iram_en, iram_read_en, iram_write_en, iram_addr, iram_wdata,
                   pc, ir, exec_valid, halted, busy};
            req = {vq[i].ack, vq[i].en, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd,
                   vq[i].pc, vq[i].ir, vq[i].ev, vq[i].hl, vq[i].bs};
            n_vec++;
            if (act !== req) begin
                $display("FAIL vec%0d: got ack/en/rd/wr=%b%b%b%b addr=%h wd=%h pc=%h ir=%h ev/hl/bs=%b%b%b, required ack/en/rd/wr=%b%b%b%b addr=%h wd=%h pc=%h ir=%h ev/hl/bs=%b%b%b",
                         i, load_ack, iram_en, iram_read_en, iram_write_en, iram_addr, iram_wdata,
                         pc, ir, exec_valid, halted, busy,
                         vq[i].ack, vq[i].en, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd,
                         vq[i].pc, vq[i].ir, vq[i].ev, vq[i].hl, vq[i].bs);
                n_bad++;
            end else begin
                $display("vec%0d pc=%h ir=%h ev=%b halted=%b", i, pc, ir, exec_valid, halted);
            end
            @(negedge clk);
        end

        // Reset during WAIT: fetch discarded, no exec_valid afterwards
        start = 1'b0; load_req = 1'b0; exec_done = 1'b0; branch_take = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("restart_fetch_rd", {31'd0, iram_read_en}, 32'd1);
        @(negedge clk); #1;
        chk("in_wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        chk("rst_wait_pc", {24'd0, pc}, 32'h00);
        chk("rst_wait_ir", {16'd0, ir}, 32'h0000);
        chk("rst_wait_status", {29'd0, busy, halted, exec_valid}, 32'd0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (exec_valid || busy) n++;
        end
        chk("rst_wait_no_exec", n, 0);

        // Start latency: start sampled at edge N, exec_valid in cycle N+3
        start = 1'b1;
        n = 0;
        for (int k = 1; k <= 10 && n == 0; k++) begin
            @(negedge clk); #1;
            if (exec_valid) n = k;
        end
        chk("start_latency", n, 3);
        chk("latency_ir", {16'd0, ir}, 32'h1005);

        // Reset in EXEC beats exec_done and start
        @(negedge clk);
        exec_done = 1'b1; reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_exec_pc", {24'd0, pc}, 32'h00);
        chk("rst_exec_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0; start = 1'b0; exec_done = 1'b0;
        @(negedge clk); #1;
        chk("rst_exec_idle", {29'd0, busy, halted, iram_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter: ADDR_W, 8, instruction RAM address / PC width.
REQ-002 Parameter: DATA_W, 16, instruction word width; opcode = bits [DATA_W-1:DATA_W-4].
REQ-003 Parameter: HALT_OP, 4'hF, opcode that stops the sequencer.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; begin or resume program execution.
REQ-007 load_req  in  1  loader requests one instruction RAM write.
REQ-008 load_addr  in  ADDR_W  loader write address.
REQ-009 load_data  in  DATA_W  loader write data.
REQ-010 load_ack  out  1  one-cycle pulse; loader write issued this cycle.
REQ-011 iram_en / iram_read_en / iram_write_en  out  1 each  instruction RAM enable, read strobe, write strobe.
REQ-012 iram_addr  out  ADDR_W; iram_wdata  out  DATA_W; iram_rdata  in  DATA_W (valid one cycle after read strobe).
REQ-013 pc  out  ADDR_W  program counter.
REQ-014 ir  out  DATA_W  instruction register.
REQ-015 exec_valid  out  1  one-cycle pulse; ir holds a new instruction for the datapath.
REQ-016 exec_done  in  1  datapath finished current instruction.
REQ-017 branch_take  in  1; branch_target  in  ADDR_W  sampled only with exec_done.
REQ-018 halted  out  1; busy  out  1  status (busy = state in FETCH, WAIT, EXEC).

Function
REQ-019 FSM states: IDLE, FETCH, WAIT, EXEC, HALT; encoding is free.
REQ-020 IDLE: load_req=1 -> iram_en=1, iram_write_en=1, iram_addr=load_addr, iram_wdata=load_data, load_ack=1 same cycle; stay IDLE.
REQ-021 IDLE: start=1 and load_req=0 -> FETCH next cycle; load_req has priority over start in the same cycle.
REQ-022 FETCH (one cycle): iram_en=1, iram_read_en=1, iram_addr=pc -> WAIT.
REQ-023 WAIT (one cycle): ir <= iram_rdata; if iram_rdata opcode == HALT_OP -> HALT, else -> EXEC.
REQ-024 exec_valid SHALL be 1 only in the first cycle of EXEC.
REQ-025 EXEC: exec_done sampled every EXEC cycle including the first; exec_done=1 -> pc <= branch_take ? branch_target : pc+1, then FETCH next cycle.
REQ-026 pc increment wraps modulo 2^ADDR_W (8'hFF -> 8'h00); no error flag.
REQ-027 HALT: halted=1, pc frozen at HALT instruction address; load_req served exactly as in IDLE (REQ-020).
REQ-028 HALT: start=1 and load_req=0 -> pc <= 0, FETCH next cycle.
REQ-029 load_req in FETCH/WAIT/EXEC SHALL be ignored (load_ack=0, no write) until IDLE or HALT; loader must hold load_req.
REQ-030 iram_read_en and iram_write_en SHALL never be 1 in the same cycle.
REQ-031 exec_done outside EXEC SHALL be ignored.
REQ-032 All iram_* strobes, load_ack, exec_valid are 0 in any cycle not listed above.
REQ-033 Fetch-to-exec latency: start sampled at edge N -> exec_valid high in cycle N+3.

Reset
REQ-034 reset=1 at any edge -> state IDLE, pc=0, ir=0, all outputs 0 next cycle, regardless of state.
REQ-035 reset mid-read (FETCH/WAIT) discards pending iram_rdata; reset has priority over start, load_req, exec_done.

Verification
REQ-036 Load 3 words (0x1005,0x2007,0xF000) at addr 0..2 in IDLE -> three load_ack pulses, write strobes with matching addr/data, no read strobes.
REQ-037 start after load, exec_done tied 1 -> exec_valid with ir=0x1005 then 0x2007, pc 0->1->2, halted=1 with pc=2, ir=0xF000.
REQ-038 Word at addr 4 with exec_done=1, branch_take=1, branch_target=0x40 -> next FETCH iram_addr=0x40.
REQ-039 pc=0xFF, exec_done=1, branch_take=0 -> pc=0x00, next fetch at addr 0x00.
REQ-040 load_req asserted during EXEC -> no load_ack until HALT reached; start and load_req together in IDLE -> write performed, FETCH deferred one cycle.
REQ-041 reset asserted in WAIT -> next cycle state IDLE, pc=0, ir=0, exec_valid never pulses for that fetch.
